// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU memory handshake bundle between an initiator (fetch/execute
// sequencers driving MAR/MDR) and the memory responder.
//   memEn  - request strobe, held high by the initiator until MFC is seen
//   R_W    - direction, 1 = read, 0 = write
//   addr   - word address from MAR
//   wdata  - write data from MDR
//   rdata  - read data back to MDR
//   MFC    - memory function complete (level, held until memEn drops)
//   busy   - access in progress
interface mem_responder_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 16
);
    logic          memEn;
    logic          R_W;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          MFC;
    logic          busy;

    modport master (
        output memEn, R_W, addr, wdata,
        input  rdata, MFC, busy
    );

    modport slave (
        input  memEn, R_W, addr, wdata,
        output rdata, MFC, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the memEn / R_W / MFC handshake.
// Captures address, write data and direction when a request arrives, waits
// WAIT_CYCLES cycles, performs the access on an internal word-addressed RAM and
// then holds MFC high until the initiator drops memEn.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - mem_responder_if slave modport (memEn, R_W, addr, wdata in;
//           rdata, MFC, busy out)
module mem_responder #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk,
    input logic            reset,
    mem_responder_if.slave bus
);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            rw_q;
    logic [DW-1:0]   rdata_q;
    logic            mfc_q;
    logic            capture;
    logic            do_access;

    logic [DW-1:0]   mem [2**AW];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture   = 1'b0;
        do_access = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.memEn) begin
                    capture = 1'b1;
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!bus.memEn) begin
                    // Initiator gave up: abandon without touching the RAM.
                    state_d = StIdle;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    do_access = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // A held memEn never re-triggers; it must drop for an edge first.
                if (!bus.memEn) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            mfc_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mfc_q   <= (state_d == StDone);
            if (capture) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                rw_q    <= bus.R_W;
            end
            if (do_access && rw_q) begin
                rdata_q <= mem[addr_q];
            end
        end
    end

    // RAM is not reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!reset && do_access && !rw_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.MFC   = mfc_q;
    assign bus.busy  = (state_q == StBusy);
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Two instances are
// driven: dut0 with WAIT_CYCLES=2 and dut1 with WAIT_CYCLES=0. Expected read
// data is pushed to a scoreboard queue when a read is issued and popped when
// MFC rises.
module tb_mem_responder;
    localparam int unsigned W0 = 2;
    localparam int unsigned W1 = 0;

    logic clk;
    logic reset;

    logic        en  [2];
    logic        rw  [2];
    logic [7:0]  ad  [2];
    logic [15:0] wd  [2];
    logic [15:0] rd  [2];
    logic        mfc [2];
    logic        bsy [2];

    mem_responder_if #(.AW(8), .DW(16)) bus0 ();
    mem_responder_if #(.AW(8), .DW(16)) bus1 ();

    assign bus0.memEn = en[0];
    assign bus0.R_W   = rw[0];
    assign bus0.addr  = ad[0];
    assign bus0.wdata = wd[0];
    assign rd[0]      = bus0.rdata;
    assign mfc[0]     = bus0.MFC;
    assign bsy[0]     = bus0.busy;

    assign bus1.memEn = en[1];
    assign bus1.R_W   = rw[1];
    assign bus1.addr  = ad[1];
    assign bus1.wdata = wd[1];
    assign rd[1]      = bus1.rdata;
    assign mfc[1]     = bus1.MFC;
    assign bsy[1]     = bus1.busy;

    mem_responder #(.AW(8), .DW(16), .WAIT_CYCLES(W0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    mem_responder #(.AW(8), .DW(16), .WAIT_CYCLES(W1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] sb [$];
    logic [15:0] model   [2][256];
    bit          written [2][256];
    logic [15:0] last_rd [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? int'(W0) : int'(W1);
    endfunction

    // One full transaction on DUT d. chg scrambles addr/wdata/R_W after the
    // capture edge and during the hold; rst_end ends it with reset instead of
    // dropping memEn.
    task automatic txn(input int d, input logic r, input logic [7:0] a, input logic [15:0] w,
                       input int hold, input bit chg, input bit rst_end);
        int          lat;
        logic [15:0] exp;
        rw[d] = r;
        ad[d] = a;
        wd[d] = w;
        en[d] = 1'b1;
        if (r) sb.push_back(model[d][a]);
        lat = 0;
        while (!mfc[d] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                check("busy_after_capture", 32'(bsy[d]), 32'd1);
                if (chg) begin
                    ad[d] = a + 8'd1;
                    wd[d] = ~w;
                    rw[d] = ~r;
                end
            end
        end
        check("latency", 32'(lat), 32'(wait_of(d) + 2));
        check("busy_in_done", 32'(bsy[d]), 32'd0);
        if (r) begin
            exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
            check("rdata", 32'(rd[d]), 32'(exp));
            last_rd[d] = exp;
        end else begin
            model[d][a]   = w;
            written[d][a] = 1'b1;
            check("rdata_after_write", 32'(rd[d]), 32'(last_rd[d]));
        end
        for (int i = 0; i < hold; i++) begin
            if (chg) wd[d] = 16'h5555;
            @(posedge clk); #1;
            check("hold_mfc", 32'(mfc[d]), 32'd1);
            check("hold_rdata", 32'(rd[d]), 32'(last_rd[d]));
        end
        if (rst_end) begin
            reset = 1'b1;
            @(posedge clk); #1;
            check("rst_in_done_mfc", 32'(mfc[d]), 32'd0);
            check("rst_in_done_rdata", 32'(rd[d]), 32'd0);
            last_rd[0] = '0;
            last_rd[1] = '0;
            reset = 1'b0;
            en[d] = 1'b0;
        end else begin
            en[d] = 1'b0;
            @(posedge clk); #1;
            check("drop_mfc", 32'(mfc[d]), 32'd0);
        end
    endtask

    // Start a write, drop memEn after one BUSY cycle; nothing must commit.
    task automatic abort_write(input int d, input logic [7:0] a, input logic [15:0] w);
        rw[d] = 1'b0;
        ad[d] = a;
        wd[d] = w;
        en[d] = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 32'(bsy[d]), 32'd1);
        @(posedge clk); #1;
        en[d] = 1'b0;
        @(posedge clk); #1;
        check("abort_idle_busy", 32'(bsy[d]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("abort_mfc", 32'(mfc[d]), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          d;
        logic [7:0]  a;
        logic        r;
        last_rd[0] = '0;
        last_rd[1] = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) begin
                model[i][j]   = '0;
                written[i][j] = 1'b0;
            end
        end

        // Reset held with a pending request on dut0.
        reset = 1'b1;
        en[0] = 1'b1; rw[0] = 1'b0; ad[0] = 8'h01; wd[0] = 16'h0101;
        en[1] = 1'b0; rw[1] = 1'b0; ad[1] = 8'h00; wd[1] = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mfc", 32'(mfc[0]), 32'd0);
        check("rst_busy", 32'(bsy[0]), 32'd0);
        check("rst_rdata", 32'(rd[0]), 32'd0);
        check("rst_rdata_dut1", 32'(rd[1]), 32'd0);
        reset = 1'b0;
        lat = 0;
        while (!mfc[0] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) check("release_capture_busy", 32'(bsy[0]), 32'd1);
        end
        check("release_latency", 32'(lat), 32'(W0 + 2));
        model[0][1]   = 16'h0101;
        written[0][1] = 1'b1;
        en[0] = 1'b0;
        @(posedge clk); #1;
        check("release_drop_mfc", 32'(mfc[0]), 32'd0);

        // Write then read, wait states = 2.
        txn(0, 1'b0, 8'h3C, 16'hBEEF, 0, 1'b0, 1'b0);
        txn(0, 1'b1, 8'h3C, 16'h0000, 3, 1'b0, 1'b0);

        // Zero wait states.
        txn(1, 1'b0, 8'h00, 16'h1234, 0, 1'b0, 1'b0);
        txn(1, 1'b1, 8'h00, 16'h0000, 1, 1'b0, 1'b0);

        // Held memEn: one access only, later wdata changes ignored.
        txn(0, 1'b0, 8'h10, 16'hAAAA, 10, 1'b1, 1'b0);
        txn(0, 1'b1, 8'h10, 16'h0000, 0, 1'b0, 1'b0);

        // Abort leaves prior contents in place.
        txn(0, 1'b0, 8'h20, 16'h1111, 0, 1'b0, 1'b0);
        abort_write(0, 8'h20, 16'h7777);
        txn(0, 1'b1, 8'h20, 16'h0000, 0, 1'b0, 1'b0);

        // Input stability during BUSY, then reset while in DONE.
        txn(0, 1'b0, 8'h05, 16'h0505, 0, 1'b0, 1'b0);
        txn(0, 1'b0, 8'h06, 16'h0606, 0, 1'b0, 1'b0);
        txn(0, 1'b1, 8'h05, 16'h0000, 1, 1'b1, 1'b1);
        txn(0, 1'b1, 8'h06, 16'h0000, 0, 1'b0, 1'b0);

        // Top of the address space.
        txn(1, 1'b0, 8'hFF, 16'hF00D, 0, 1'b0, 1'b0);
        txn(1, 1'b1, 8'hFF, 16'h0000, 0, 1'b0, 1'b0);

        // Random traffic; reads only target addresses already written.
        for (int i = 0; i < 30; i++) begin
            d = int'($urandom_range(0, 1));
            a = 8'($urandom_range(0, 15));
            r = 1'($urandom_range(0, 1)) && written[d][a];
            txn(d, r, a, 16'($urandom), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
